// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // One-hot completion vector for a port index.
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; a tie goes to the port not served last.
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pick a single winner from the live request bits.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = PORT_CPU;
        if (req == 2'b11) begin
            gnt_idx = ~last_served;
        end else if (req[1]) begin
            gnt_idx = PORT_AUX;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the CPU port and an auxiliary port.
// Every SRAM strobe is its own flop so the pads never see decode glitches.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_DQ_out,
    output logic              SRAM_DQ_oe,
    input  logic [DATA_W-1:0] SRAM_DQ_in,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_UB,
    output logic              Mem_LB
);

    localparam int unsigned       CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t       state;
    logic             grant;
    logic             we_q;
    logic             last_served;
    logic [CNT_W-1:0] cnt;
    logic             gnt_valid;
    logic             gnt_idx;

    rr_arbiter2 u_rr (
        .req        (req),
        .last_served(last_served),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // Access sequencer: grant in IDLE, hold strobes for the access, pulse done.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ARB_IDLE;
            grant       <= PORT_CPU;
            we_q        <= 1'b0;
            last_served <= PORT_AUX;
            cnt         <= '0;
            done        <= 2'b00;
            rdata0      <= '0;
            rdata1      <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            Mem_CE      <= 1'b1;
            Mem_OE      <= 1'b1;
            Mem_WE      <= 1'b1;
            Mem_UB      <= 1'b1;
            Mem_LB      <= 1'b1;
        end else begin
            done <= 2'b00;
            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        state       <= ARB_ACCESS;
                        grant       <= gnt_idx;
                        we_q        <= we[gnt_idx];
                        cnt         <= CNT_LOAD;
                        SRAM_ADDR   <= gnt_idx ? addr1 : addr0;
                        SRAM_DQ_out <= gnt_idx ? wdata1 : wdata0;
                        // Strobes are loaded here so they are valid for the whole access.
                        Mem_CE      <= 1'b0;
                        Mem_UB      <= 1'b0;
                        Mem_LB      <= 1'b0;
                        Mem_OE      <= we[gnt_idx];
                        Mem_WE      <= ~we[gnt_idx];
                        SRAM_DQ_oe  <= we[gnt_idx];
                    end
                end

                ARB_ACCESS: begin
                    if (cnt == '0) begin
                        if (!we_q) begin
                            if (grant == PORT_AUX) begin
                                rdata1 <= SRAM_DQ_in;
                            end else begin
                                rdata0 <= SRAM_DQ_in;
                            end
                        end
                        state      <= ARB_DONE;
                        done       <= port_onehot(grant);
                        Mem_CE     <= 1'b1;
                        Mem_OE     <= 1'b1;
                        Mem_WE     <= 1'b1;
                        Mem_UB     <= 1'b1;
                        Mem_LB     <= 1'b1;
                        SRAM_DQ_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ARB_DONE: begin
                    last_served <= grant;
                    state       <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vectors, corner sequences,
// and random two-port traffic checked against a transaction-level model.
module tb_sram_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;
    localparam int unsigned W  = 2;
    localparam int          N  = 4096;

    logic          Clk;
    logic          Reset;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    done;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] SRAM_ADDR;
    logic [DW-1:0] SRAM_DQ_out;
    logic          SRAM_DQ_oe;
    logic [DW-1:0] SRAM_DQ_in;
    logic          Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;

    int n_asserts = 0;
    int n_fail    = 0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done(done), .rdata0(rdata0), .rdata1(rdata1),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_DQ_in(SRAM_DQ_in),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM pin model and reference memory ----------------
    logic [DW-1:0] sram_mem [int];
    logic [DW-1:0] ref_mem  [int];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A5};
    endfunction

    function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
        if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    // Pads only carry data while the chip is selected and output-enabled.
    always @(negedge Clk)
        SRAM_DQ_in <= (!Mem_CE && !Mem_OE) ? sram_rd(SRAM_ADDR) : 16'hDEAD;

    always @(posedge Clk)
        if (!Mem_CE && !Mem_WE && SRAM_DQ_oe) sram_mem[int'(SRAM_ADDR)] = SRAM_DQ_out;

    // ---------------- cycle histories for the transaction monitor ----------------
    int            cyc = 0;
    int            ci;
    logic          ls_m = 1'b1;
    logic [1:0]    req_h [N];
    logic [1:0]    we_h  [N];
    logic [AW-1:0] a0_h  [N];
    logic [AW-1:0] a1_h  [N];
    logic [DW-1:0] d0_h  [N];
    logic [DW-1:0] d1_h  [N];
    logic [3:0]    strb_h[N];
    logic [AW-1:0] sa_h  [N];
    logic [DW-1:0] dqo_h [N];
    logic [1:0]    done_h[N];

    always @(posedge Clk) begin
        cyc = cyc + 1;
        req_h[cyc % N] = req;
        we_h[cyc % N]  = we;
        a0_h[cyc % N]  = addr0;
        a1_h[cyc % N]  = addr1;
        d0_h[cyc % N]  = wdata0;
        d1_h[cyc % N]  = wdata1;
        if (Reset) ls_m = 1'b1;
    end

    // A completion in cycle c implies a grant edge at c-W; audit the whole access.
    task automatic check_done(input int c);
        int            g;
        logic          p, w, exp_p;
        logic [1:0]    r;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        g = c - int'(W);
        chk_eq("done_onehot", 32'($countones(done)), 32'd1);
        p = done[1];
        r = req_h[g % N];
        exp_p = (r == 2'b11) ? ~ls_m : r[1];
        chk_eq("grant_had_req", 32'(r[p]), 32'd1);
        chk_eq("grant_port", 32'(p), 32'(exp_p));
        w = we_h[g % N][p];
        a = p ? a1_h[g % N] : a0_h[g % N];
        d = p ? d1_h[g % N] : d0_h[g % N];
        for (int i = 0; i < int'(W); i++) begin
            chk_eq("access_strobes", 32'(strb_h[(g + i) % N]), 32'({1'b0, w, ~w, w}));
            chk_eq("access_addr", 32'(sa_h[(g + i) % N]), 32'(a));
            if (w) chk_eq("write_data", 32'(dqo_h[(g + i) % N]), 32'(d));
        end
        chk_eq("idle_strobes_before", 32'(strb_h[(g - 1) % N]), 32'h0E);
        chk_eq("done_strobes", 32'(strb_h[c % N]), 32'h0E);
        if (!w) chk_eq("rdata", 32'(p ? rdata1 : rdata0), 32'(ref_rd(a)));
        else    ref_mem[int'(a)] = d;
        ls_m = p;
    endtask

    always @(negedge Clk) begin
        ci = cyc % N;
        strb_h[ci] = {Mem_CE, Mem_OE, Mem_WE, SRAM_DQ_oe};
        sa_h[ci]   = SRAM_ADDR;
        dqo_h[ci]  = SRAM_DQ_out;
        done_h[ci] = done;
        chk_eq("ub_lb_follow_ce", 32'({Mem_UB, Mem_LB}), 32'({Mem_CE, Mem_CE}));
        if (cyc > 1) chk_eq("done_back_to_back", 32'(done_h[(cyc - 1) % N] & done), 32'd0);
        if (done != 2'b00) begin
            if (cyc >= int'(W) + 2) check_done(cyc);
            else chk_eq("done_too_early", 32'(done), 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge Clk);
        req = 2'b00;
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b0;
    endtask

    // One isolated access; returns the port's rdata and negedges until done.
    task automatic single(input logic p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
        @(negedge Clk);
        we[p] = w;
        if (p) begin addr1 = a; wdata1 = d; end
        else   begin addr0 = a; wdata0 = d; end
        req[p] = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge Clk);
            lat++;
            if (done[p]) break;
            if (lat > 40) begin
                chk_eq("single_timeout", 32'(lat), 32'(W + 1));
                break;
            end
        end
        req[p] = 1'b0;
        rd = p ? rdata1 : rdata0;
    endtask

    task automatic set_port(input int p);
        logic [AW-1:0] a;
        a = 20'h00100 + AW'($urandom_range(0, 15));
        we[p] = 1'($urandom_range(0, 1));
        if (p == 0) begin addr0 = a; wdata0 = 16'($urandom); end
        else        begin addr1 = a; wdata1 = 16'($urandom); end
        req[p] = 1'b1;
    endtask

    typedef struct {
        logic          port;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t          vecs[9];
    logic [DW-1:0] hold[2];
    logic [DW-1:0] rd;
    int            lat, k, tprev, tfirst;
    int            wait_cnt[2];

    initial begin
        Reset = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        sram_mem[int'(20'h00010)] = 16'h1234;
        ref_mem[int'(20'h00010)]  = 16'h1234;

        vecs[0] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 20'h0ABCD, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 20'h0ABCD, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b0, 20'h0ABCD, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b1, 20'hFFFFF, 16'h0001, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 20'hFFFFF, 16'h0000, 16'h0001};
        vecs[6] = '{1'b0, 1'b1, 20'h00000, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 20'h00000, 16'h0000, 16'hFFFF};
        vecs[8] = '{1'b1, 1'b0, 20'h00010, 16'h0000, 16'h1234};

        // Reset state.
        repeat (2) @(negedge Clk);
        chk_eq("rst_strobes", 32'({Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, SRAM_DQ_oe}), 32'h3E);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_rdata0", 32'(rdata0), 32'd0);
        chk_eq("rst_rdata1", 32'(rdata1), 32'd0);
        chk_eq("rst_addr", 32'(SRAM_ADDR), 32'd0);
        #2 Reset = 1'b0;

        // Directed single-port vectors; rdata of a port holds across its writes.
        hold[0] = '0; hold[1] = '0;
        for (int i = 0; i < 9; i++) begin
            single(vecs[i].port, vecs[i].w, vecs[i].a, vecs[i].d, rd, lat);
            if (!vecs[i].w) hold[vecs[i].port] = vecs[i].exp_rd;
            chk_eq($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
            chk_eq($sformatf("vec%0d_rdata0", i), 32'(rdata0), 32'(hold[0]));
            chk_eq($sformatf("vec%0d_rdata1", i), 32'(rdata1), 32'(hold[1]));
        end

        // Both ports raise together after reset and hold: strict 0,1,0,1.
        do_reset();
        @(negedge Clk);
        we = 2'b00; addr0 = 20'h00010; addr1 = 20'h0ABCD; req = 2'b11;
        k = 0; tprev = 0; tfirst = 0;
        for (int t = 1; t <= 40 && k < 4; t++) begin
            @(negedge Clk);
            if (done != 2'b00) begin
                chk_eq("alt_order", 32'(done), 32'((k % 2 == 0) ? 2'b01 : 2'b10));
                if (k == 0) tfirst = t;
                else chk_eq("alt_spacing", 32'(t - tprev), 32'(W + 2));
                tprev = t;
                k++;
            end
        end
        req = 2'b00;
        chk_eq("alt_count", 32'(k), 32'd4);
        chk_eq("alt_first_latency", 32'(tfirst), 32'(W + 1));

        // Reset in the first write-strobe cycle aborts the access.
        do_reset();
        @(negedge Clk);
        we[1] = 1'b1; addr1 = 20'h00200; wdata1 = 16'h7777; req[1] = 1'b1;
        k = 0;
        while (Mem_WE !== 1'b0 && k < 10) begin
            @(negedge Clk);
            k++;
        end
        chk_eq("abort_we_seen", 32'(Mem_WE), 32'd0);
        #2 Reset = 1'b1;
        #1 chk_eq("abort_strobes_async", 32'({Mem_CE, Mem_WE, SRAM_DQ_oe}), 32'h6);
        req = 2'b00;
        for (int t = 0; t < 3; t++) begin
            @(negedge Clk);
            chk_eq("abort_no_done", 32'(done), 32'd0);
        end
        #2 Reset = 1'b0;
        single(1'b0, 1'b0, 20'h00010, 16'h0000, rd, lat);
        chk_eq("after_abort_latency", 32'(lat), 32'(W + 1));
        chk_eq("after_abort_rdata", 32'(rd), 32'h1234);

        // Port 0 holds req continuously: one completion per W+2 cycles.
        @(negedge Clk);
        we[0] = 1'b0; addr0 = 20'h0ABCD; req[0] = 1'b1;
        k = 0; tprev = 0;
        for (int t = 1; t <= 40 && k < 5; t++) begin
            @(negedge Clk);
            if (done != 2'b00) begin
                chk_eq("held_port", 32'(done), 32'h1);
                chk_eq("held_rdata", 32'(rdata0), 32'hBEEF);
                if (k > 0) chk_eq("held_spacing", 32'(t - tprev), 32'(W + 2));
                tprev = t;
                k++;
            end
        end
        req = 2'b00;
        chk_eq("held_count", 32'(k), 32'd5);

        // Random two-port traffic; each requester follows the drop-on-done rule.
        @(negedge Clk);
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        for (int t = 0; t < 800; t++) begin
            @(negedge Clk);
            for (int p = 0; p < 2; p++) begin
                if (req[p]) begin
                    wait_cnt[p]++;
                    if (done[p]) begin
                        chk_eq("wait_bound", 32'(wait_cnt[p] <= int'(2 * (W + 2))), 32'd1);
                        wait_cnt[p] = 0;
                        if ($urandom_range(0, 3) == 0) set_port(p);
                        else req[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_port(p);
                    wait_cnt[p] = 0;
                end
            end
        end
        for (int p = 0; p < 2; p++)
            if (req[p]) chk_eq("final_wait_bound", 32'(wait_cnt[p] <= int'(2 * (W + 2))), 32'd1);
        req = 2'b00;
        repeat (10) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the single asynchronous 16-bit SRAM behind the SLC-3 datapath. It shares the SRAM between the CPU memory port (port 0, driven by the MAR/MDR path under ISDU control) and an auxiliary port (port 1, program loader / debug reader). It owns all SRAM control strobes, replacing the fixed Mem_* tie-offs. Port selection is round-robin, and each access uses a parameterised number of strobe cycles.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, data width
- WAIT_CYCLES, 2, cycles the OE or WE strobe is held per access; minimum 1

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high
- req  in  2  per-port request, level; bit 0 is CPU, bit 1 is auxiliary
- we  in  2  per-port write flag; sampled with req
- addr0, addr1  in  ADDR_W  per-port word address
- wdata0, wdata1  in  DATA_W  per-port write data
- done  out  2  per-port one-cycle completion pulse
- rdata0, rdata1  out  DATA_W  per-port read data; held until that port's next completed read
- SRAM_ADDR  out  ADDR_W  SRAM address
- SRAM_DQ_out  out  DATA_W  write data to the pad driver
- SRAM_DQ_oe  out  1  pad drive enable, active-high
- SRAM_DQ_in  in  DATA_W  read data from the pads
- Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB  out  1 each  SRAM strobes, active-low

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - If one req bit is set, grant that port.
  - If both are set, grant the port that is not last_served.
  - On grant, register the port index, addr, we and wdata. Go to ACCESS with the counter set to WAIT_CYCLES-1.
- ACCESS:
  - Mem_CE=0, Mem_UB=0, Mem_LB=0.
  - Read: Mem_OE=0.
  - Write: Mem_WE=0, SRAM_DQ_oe=1, SRAM_DQ_out = registered wdata.
  - SRAM_ADDR is the registered address, constant for the whole access.
  - Counter decrements each cycle. On the cycle the counter is 0:
    - for a read, capture SRAM_DQ_in into rdata of the granted port;
    - go to DONE.
- DONE:
  - All strobes high. done[grant]=1 for exactly this cycle.
  - last_served is set to grant. Go to IDLE.
- Requester rule: the requester drops req on the edge that samples done=1. If req is still high in the following IDLE cycle, it is a new request.
- The req inputs are ignored outside IDLE. Inputs changing mid-access have no effect, because the access uses registered copies.
- Outside ACCESS: Mem_CE, Mem_OE, Mem_WE, Mem_UB and Mem_LB are all 1, and SRAM_DQ_oe=0.
- The strobes come straight from flops (state and we registers ANDed only with registered terms), so they are glitch-free.
- Reset values:
  - state IDLE, last_served=1 (port 0 wins the first tie), grant=0;
  - done=0, rdata0=rdata1=0, SRAM_ADDR=0;
  - all strobes 1, SRAM_DQ_oe=0.
- Reset during ACCESS aborts the access: strobes go high asynchronously, no done is issued, and a partial write is not retried.

## Timing
- Request sampled in IDLE at cycle 0 → ACCESS in cycles 1..WAIT_CYCLES → DONE (done=1) in cycle WAIT_CYCLES+1.
- rdata is valid in the DONE cycle and stays valid afterwards.
- One access per WAIT_CYCLES+2 cycles. With WAIT_CYCLES=2 that is 4 cycles, which matches the ISDU two-cycle memory states plus setup.
- Sustained requests from both ports alternate strictly: 0,1,0,1. Neither port waits more than one access of the other port.
- Counter width is $clog2(WAIT_CYCLES+1); with WAIT_CYCLES=1 the counter starts at 0.

## Structure
- Package sram_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_DONE};
  - constants PORT_CPU=0 and PORT_AUX=1.
- Sub-module rr_arbiter2 is combinational. Inputs: req[1:0], last_served. Outputs: gnt_valid, gnt_idx.
- Top level: FSM, counter, address/data/we registers, rdata registers, strobe flops.

## Test plan
- Reset → all Mem_* = 1, SRAM_DQ_oe=0, done=00, rdata0=rdata1=0x0000.
- Port 0 read, addr0=0x00010, SRAM model holding 0x1234, WAIT_CYCLES=2:
  - Mem_OE low in cycles 1–2 only, Mem_WE high throughout;
  - done=01 in cycle 3, rdata0=0x1234.
- Port 1 write, addr1=0x0ABCD, wdata1=0xBEEF:
  - SRAM_ADDR=0x0ABCD, Mem_WE low and SRAM_DQ_oe high for exactly 2 cycles, done=10.
  - A following port 0 read of 0x0ABCD returns 0xBEEF.
- Both req bits set in the same cycle after reset, held: grants go 0,1,0,1, with done pulses 4 cycles apart.
- Reset asserted in the first ACCESS cycle of a write:
  - Mem_WE goes high before the next edge, no done is issued;
  - after release, state is IDLE and the next request completes normally.
- Port 0 req held high continuously, port 1 idle: port 0 completes every 4 cycles, done0 is never high for 2 consecutive cycles, and there are no strobe glitches between accesses.
